inst_axi_bridge: RTL and testbench

Instruction-side bridge between the IF stage's SRAM-like fetch port and an AXI4 read master. It accepts fetch requests from IF, issues single-beat AXI reads, and returns exactly one in-order `data_ok` per accepted request, including requests that IF has since cancelled. IF relies on that guarantee to drain its cancel state. The block is read-only, and its AXI ports connect to the top-level interconnect/arbiter.

---
 rtl/inst_axi_bridge_pkg.sv | 24 ++
 rtl/inst_axi_bridge_if.sv | 59 +++++
 rtl/inst_axi_bridge.sv | 125 ++++++++++++
 tb/tb_inst_axi_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_axi_bridge_pkg                                                        |
// | Shared AXI encodings and AR-channel state codes for the fetch bridge.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package inst_axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

   typedef logic [0:0] ar_state_t;
   localparam ar_state_t AR_IDLE = 1'b0;
   localparam ar_state_t AR_BUSY = 1'b1;

   // SRAM-side size is log2(bytes) in 2 bits; AXI arsize is the same code in 3.
   function automatic logic [2:0] axi_size(input logic [1:0] log2_bytes);
      return {1'b0, log2_bytes};
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_axi_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_axi_bridge_if                                                         |
// | IF-stage SRAM-like fetch port plus AXI4 read channels seen by the bridge.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface inst_axi_bridge_if;

   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // master: the bridge (answers IF, masters AXI); slave: IF stage + interconnect.
   modport master (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface
`default_nettype wire

// File: rtl/inst_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_axi_bridge                                                            |
// | Fetch-port to AXI4 single-beat read bridge; one in-order data_ok per accept.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_axi_bridge
   import inst_axi_bridge_pkg::*;
#(
   parameter int         OUTSTANDING = 2,
   parameter logic [3:0] AXI_ID      = AXI_ID_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   inst_axi_bridge_if.master bus,
   output logic              bus_err
);

   localparam int               CNT_W   = $clog2(OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);

   ar_state_t        ar_state_q;
   ar_state_t        ar_state_d;
   logic [31:0]      araddr_q;
   logic [2:0]       arsize_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic             w_arvalid;
   logic             w_rready;
   logic             w_addr_ok;
   logic             w_data_ok;

   // Full check uses registered cnt, so a same-cycle return does not free a slot.
   assign w_rready  = (cnt_q != '0);
   assign w_addr_ok = bus.inst_sram_req && !bus.inst_sram_wr &&
                      (ar_state_q == AR_IDLE) && (cnt_q < CNT_MAX);
   assign w_data_ok = bus.rvalid && w_rready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ar_state_q <= AR_IDLE;
      end else begin
         ar_state_q <= ar_state_d;
      end
   end

   always_comb begin
      ar_state_d = ar_state_q;
      case (ar_state_q)
         AR_IDLE: if (w_addr_ok)   ar_state_d = AR_BUSY;
         AR_BUSY: if (bus.arready) ar_state_d = AR_IDLE;
         default:                  ar_state_d = AR_IDLE;
      endcase
   end

   always_comb begin
      w_arvalid = 1'b0;
      case (ar_state_q)
         AR_BUSY: w_arvalid = 1'b1;
         default: w_arvalid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         araddr_q <= '0;
         arsize_q <= AXI_SIZE_WORD;
      end else if (w_addr_ok) begin
         araddr_q <= bus.inst_sram_addr;
         arsize_q <= axi_size(bus.inst_sram_size);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({w_addr_ok, w_data_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.arid    = AXI_ID;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = 8'd0;
   assign bus.arsize  = arsize_q;
   assign bus.arburst = AXI_BURST_INCR;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.arvalid = w_arvalid;
   assign bus.rready  = w_rready;

   // No data buffer: IF consumes every data_ok in the cycle it appears.
   assign bus.inst_sram_addr_ok = w_addr_ok;
   assign bus.inst_sram_data_ok = w_data_ok;
   assign bus.inst_sram_rdata   = bus.rdata;
   assign bus_err               = w_data_ok && (bus.rresp != AXI_RESP_OKAY);

   logic w_unused;
   assign w_unused = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rlast};

   a_no_write: assert property (@(posedge clk) disable iff (!resetn)
      !(bus.inst_sram_req && bus.inst_sram_wr));

   a_single_beat: assert property (@(posedge clk) disable iff (!resetn)
      w_data_ok |-> (bus.rlast && (bus.rid == AXI_ID)));

   a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
      cnt_q <= CNT_MAX);

   a_ar_stable: assert property (@(posedge clk) disable iff (!resetn)
      (w_arvalid && !bus.arready) |=> (w_arvalid && $stable(araddr_q) && $stable(arsize_q)));

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_axi_bridge                                                         |
// | Random IF/AXI-slave stimulus with a cycle model and in-order scoreboard.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_axi_bridge;

   localparam int OUTSTANDING = 2;

   logic clk;
   logic resetn;
   logic bus_err;

   inst_axi_bridge_if bus ();

   inst_axi_bridge #(
      .OUTSTANDING (OUTSTANDING),
      .AXI_ID      (4'd0)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .bus     (bus),
      .bus_err (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] s_q[$];
   logic        r_hold;
   logic        last_acc;
   logic        first_req;
   int unsigned p_req, p_arr, p_rv, p_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Backing memory of the simulated slave.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1e80_0000;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h1c00_0000 | ($urandom & 32'h0000_fffc);
   endfunction

   // Monitor: cycle-level model of the accept/return rules plus scoreboard pop.
   int          m_out;
   logic        m_pend;
   logic [31:0] m_addr;
   logic        e_ao, e_dok;
   logic [31:0] e_data;

   always @(negedge clk) begin
      if (!resetn) begin
         m_out  = 0;
         m_pend = 1'b0;
         m_addr = '0;
         exp_q.delete();
      end else begin
         e_ao  = bus.inst_sram_req && !bus.inst_sram_wr && !m_pend && (m_out < OUTSTANDING);
         e_dok = bus.rvalid && (m_out != 0);
         chk("addr_ok", {31'd0, bus.inst_sram_addr_ok}, {31'd0, e_ao});
         chk("arvalid", {31'd0, bus.arvalid}, {31'd0, m_pend});
         chk("rready", {31'd0, bus.rready}, {31'd0, (m_out != 0)});
         chk("data_ok", {31'd0, bus.inst_sram_data_ok}, {31'd0, e_dok});
         chk("ar_const", {9'd0, bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
             {9'd0, 4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
         if (m_pend) begin
            chk("araddr", bus.araddr, m_addr);
            chk("arsize", {29'd0, bus.arsize}, 32'd2);
         end
         if (bus.inst_sram_data_ok) begin
            chk("exp_q_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
               e_data = exp_q.pop_front();
               chk("rdata", bus.inst_sram_rdata, e_data);
            end
            chk("bus_err", {31'd0, bus_err}, {31'd0, (bus.rresp != 2'b00)});
         end else begin
            chk("bus_err_idle", {31'd0, bus_err}, 32'd0);
         end
         if (m_pend && bus.arready) m_pend = 1'b0;
         if (e_ao) begin
            m_pend = 1'b1;
            m_addr = bus.inst_sram_addr;
         end
         m_out = m_out + int'(e_ao) - int'(e_dok);
      end
   end

   task automatic drive_next(input logic acc);
      int unsigned r;
      bus.arready = ($urandom_range(99) < p_arr);
      if (bus.inst_sram_req && !acc) begin
         // IF may cancel or redirect a request that has not been accepted yet.
         r = $urandom_range(99);
         if (r < 10)      bus.inst_sram_req  = 1'b0;
         else if (r < 30) bus.inst_sram_addr = rand_addr();
      end else begin
         bus.inst_sram_req  = ($urandom_range(99) < p_req);
         bus.inst_sram_addr = rand_addr();
         if (bus.inst_sram_req && first_req) begin
            bus.inst_sram_addr = 32'h1c00_0000;
            first_req = 1'b0;
         end
      end
      bus.inst_sram_wstrb = 4'($urandom);
      bus.inst_sram_wdata = $urandom;
      if (!r_hold && (s_q.size() != 0) && ($urandom_range(99) < p_rv)) begin
         r_hold     = 1'b1;
         bus.rdata  = mem(s_q[0]);
         bus.rresp  = ($urandom_range(99) < p_err) ? 2'b10 : 2'b00;
      end
      if (!r_hold) begin
         bus.rdata = $urandom;
         bus.rresp = 2'($urandom);
      end
      bus.rvalid = r_hold;
   endtask

   task automatic cycle();
      logic        hs_ar, hs_r, acc;
      logic [31:0] a_ar;
      @(negedge clk);
      hs_ar = bus.arvalid && bus.arready;
      a_ar  = bus.araddr;
      hs_r  = bus.rvalid && bus.rready;
      acc   = bus.inst_sram_addr_ok;
      if (acc) exp_q.push_back(mem(bus.inst_sram_addr));
      @(posedge clk);
      #1;
      if (hs_r && r_hold) begin
         s_q.delete(0);
         r_hold = 1'b0;
      end
      if (hs_ar) s_q.push_back(a_ar);
      last_acc = acc;
      drive_next(acc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_arvalid"}, {31'd0, bus.arvalid}, 32'd0);
      chk({tag, "_araddr"}, bus.araddr, 32'd0);
      chk({tag, "_arsize"}, {29'd0, bus.arsize}, 32'd2);
      chk({tag, "_rready"}, {31'd0, bus.rready}, 32'd0);
      chk({tag, "_addr_ok"}, {31'd0, bus.inst_sram_addr_ok}, 32'd0);
      chk({tag, "_data_ok"}, {31'd0, bus.inst_sram_data_ok}, 32'd0);
      chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
   endtask

   int unsigned PH_REQ[4] = '{70, 90, 60, 50};
   int unsigned PH_ARR[4] = '{100, 20, 80, 60};
   int unsigned PH_RV[4]  = '{100, 70, 10, 50};
   int unsigned PH_ERR[4] = '{0, 10, 10, 40};
   logic        busy;

   initial begin
      resetn              = 1'b0;
      bus.inst_sram_req   = 1'b0;
      bus.inst_sram_wr    = 1'b0;
      bus.inst_sram_size  = 2'b10;
      bus.inst_sram_wstrb = 4'd0;
      bus.inst_sram_addr  = '0;
      bus.inst_sram_wdata = '0;
      bus.arready         = 1'b0;
      bus.rid             = 4'd0;
      bus.rdata           = '0;
      bus.rresp           = 2'b00;
      bus.rlast           = 1'b1;
      bus.rvalid          = 1'b0;
      r_hold              = 1'b0;
      last_acc            = 1'b0;
      first_req           = 1'b1;
      p_req = 0; p_arr = 100; p_rv = 100; p_err = 0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      resetn = 1'b1;

      for (int ph = 0; ph < 4; ph++) begin
         p_req = PH_REQ[ph];
         p_arr = PH_ARR[ph];
         p_rv  = PH_RV[ph];
         p_err = PH_ERR[ph];
         for (int i = 0; i < 300; i++) cycle();
      end

      // Drain: no new requests, every accepted fetch must come back.
      bus.inst_sram_req = 1'b0;
      p_req = 0; p_arr = 100; p_rv = 100; p_err = 0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle();
      cycle();
      cycle();
      chk("drain_empty", exp_q.size(), 32'd0);
      chk("drain_rready", {31'd0, bus.rready}, 32'd0);

      // Reset while a read address is held in AR_BUSY.
      p_req = 100; p_arr = 0;
      busy  = 1'b0;
      for (int i = 0; i < 20 && !busy; i++) begin
         cycle();
         busy = last_acc;
      end
      chk("reach_ar_busy", {31'd0, busy}, 32'd1);
      #2;
      chk("pre_reset_arvalid", {31'd0, bus.arvalid}, 32'd1);
      chk("pre_reset_rready", {31'd0, bus.rready}, 32'd1);
      resetn            = 1'b0;
      bus.inst_sram_req = 1'b0;
      bus.rvalid        = 1'b0;
      bus.arready       = 1'b0;
      r_hold            = 1'b0;
      s_q.delete();
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // rvalid with nothing outstanding must not be taken.
      p_req = 0; p_arr = 100; p_rv = 100;
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hdead_beef;
      bus.rresp  = 2'b10;
      cycle();
      for (int i = 0; i < 5; i++) cycle();
      chk("final_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
